// File: rtl/dekatron_pkg.sv
// Shared constants and FSM encoding for the dekatron chain sequencer.
package dekatron_pkg;
  localparam int WIDTH = 10;
  localparam logic [WIDTH-1:0] POS0 = 10'b0000000001;
  localparam logic [WIDTH-1:0] POS9 = 10'b1000000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EVAL  = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/dekatron_chain_ctrl_if.sv
// Host request/status and dekatron drive/readback signals for the chain sequencer.
interface dekatron_chain_ctrl_if
  import dekatron_pkg::*;
#(parameter int DIGITS = 3);
  logic                          Request;
  logic                          Dec;
  logic                          Load;
  logic [DIGITS-1:0][WIDTH-1:0]  SetValue;
  logic [DIGITS-1:0][WIDTH-1:0]  DigitOut;
  logic [DIGITS-1:0]             DigitStep;
  logic                          DigitReverse;
  logic                          DigitSet;
  logic [DIGITS-1:0][WIDTH-1:0]  DigitIn;
  logic                          Ready;
  logic                          Done;
  logic                          Overflow;
  logic                          Error;
  logic                          Zero;

  // Host plus dekatron side (drives requests and the Out readback)
  modport master (
    output Request, Dec, Load, SetValue, DigitOut,
    input  DigitStep, DigitReverse, DigitSet, DigitIn, Ready, Done, Overflow, Error, Zero
  );

  // Sequencer side
  modport slave (
    input  Request, Dec, Load, SetValue, DigitOut,
    output DigitStep, DigitReverse, DigitSet, DigitIn, Ready, Done, Overflow, Error, Zero
  );
endinterface

// File: rtl/dekatron_onehot_decode.sv
// Classifies one dekatron position bus: exactly one-hot, at position 0, at position 9.
module dekatron_onehot_decode
  import dekatron_pkg::*;
(
  input  logic [WIDTH-1:0] onehot,
  output logic             is_valid,
  output logic             is_zero,
  output logic             is_nine
);
  // Power-of-two test: nonzero and clearing the lowest set bit leaves nothing
  assign is_valid = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);
  assign is_zero  = (onehot == POS0);
  assign is_nine  = (onehot == POS9);
endmodule

// File: rtl/dekatron_chain_ctrl.sv
// Sequencer turning a chain of dekatron ring counters into a decimal up/down
// counter; carry/borrow ripples one digit at a time, reading each tube back.
module dekatron_chain_ctrl
  import dekatron_pkg::*;
#(parameter int DIGITS = 3)
(
  input  logic                 Clk,
  input  logic                 Rst,
  dekatron_chain_ctrl_if.slave bus
);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  state_t                        r_state;
  logic                          r_dec, r_load, r_carry;
  logic [2:0]                    r_k;
  logic [DIGITS-1:0]             r_sel;
  logic [DIGITS-1:0]             r_DigitStep;
  logic                          r_DigitReverse, r_DigitSet;
  logic [DIGITS-1:0][WIDTH-1:0]  r_DigitIn;
  logic                          r_Ready, r_Done, r_Overflow, r_Error, r_Zero;

  logic [DIGITS-1:0] w_out_valid, w_out_zero, w_out_nine;
  logic [DIGITS-1:0] w_set_valid, w_set_unused_zero, w_set_unused_nine;
  logic [DIGITS-1:0] w_ksel;
  logic              w_k_valid, w_k_zero, w_k_nine;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    dekatron_onehot_decode u_out (
      .onehot(bus.DigitOut[g]), .is_valid(w_out_valid[g]),
      .is_zero(w_out_zero[g]),  .is_nine(w_out_nine[g]));
    dekatron_onehot_decode u_set (
      .onehot(bus.SetValue[g]),      .is_valid(w_set_valid[g]),
      .is_zero(w_set_unused_zero[g]), .is_nine(w_set_unused_nine[g]));
  end

  // Select the digit currently being evaluated without a wide index
  assign w_ksel    = DIGITS'(1) << r_k;
  assign w_k_valid = |(w_ksel & w_out_valid);
  assign w_k_zero  = |(w_ksel & w_out_zero);
  assign w_k_nine  = |(w_ksel & w_out_nine);

  // Sequencer FSM; every output is a flop so Step never glitches
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state        <= S_IDLE;
      r_dec          <= 1'b0;
      r_load         <= 1'b0;
      r_carry        <= 1'b0;
      r_k            <= '0;
      r_sel          <= '0;
      r_DigitStep    <= '0;
      r_DigitReverse <= 1'b0;
      r_DigitSet     <= 1'b0;
      r_DigitIn      <= '0;
      r_Ready        <= 1'b1;
      r_Done         <= 1'b0;
      r_Overflow     <= 1'b0;
      r_Error        <= 1'b0;
      r_Zero         <= 1'b1;
    end else begin
      r_DigitStep <= '0;
      r_Done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_Ready) r_Ready <= 1'b1;
          else if (bus.Request) begin
            r_dec      <= bus.Dec;
            r_load     <= bus.Load;
            r_Overflow <= 1'b0;
            r_Error    <= 1'b0;
            r_Ready    <= 1'b0;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_load) begin
            if (!(&w_set_valid)) begin
              r_Error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_DigitIn  <= bus.SetValue;
              r_DigitSet <= 1'b1;
              r_sel      <= '1;
              r_state    <= S_PULSE;
            end
          end else begin
            r_DigitReverse <= r_dec;
            r_DigitSet     <= 1'b0;
            r_state        <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Decide carry from the digit's position before it is stepped
          if (!w_k_valid) begin
            r_Error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_carry <= r_dec ? w_k_zero : w_k_nine;
            r_sel   <= w_ksel;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          r_DigitStep <= r_sel;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (r_load || !r_carry) r_state <= S_DONE;
          else if (r_k == LAST) begin
            r_Overflow <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_k     <= r_k + 3'd1;
            r_state <= S_EVAL;
          end
        end
        S_DONE: begin
          r_Done         <= 1'b1;
          r_Zero         <= &w_out_zero;
          r_DigitSet     <= 1'b0;
          r_DigitIn      <= '0;
          r_DigitReverse <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.DigitStep    = r_DigitStep;
  assign bus.DigitReverse = r_DigitReverse;
  assign bus.DigitSet     = r_DigitSet;
  assign bus.DigitIn      = r_DigitIn;
  assign bus.Ready        = r_Ready;
  assign bus.Done         = r_Done;
  assign bus.Overflow     = r_Overflow;
  assign bus.Error        = r_Error;
  assign bus.Zero         = r_Zero;
endmodule

// File: tb/tb_dekatron_chain_ctrl.sv
// Bench for dekatron_chain_ctrl: behavioural dekatron tubes on the bus and a
// decimal-arithmetic reference for values, pulse counts and latency.
module tb_dekatron_chain_ctrl;
  localparam int D = 3;
  localparam int M = 10 ** D;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  dekatron_chain_ctrl_if #(.DIGITS(D)) bus ();
  dekatron_chain_ctrl #(.DIGITS(D)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  function automatic int oh2i(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Tube models: step on rising Step, load from In when Set, reset with Rst
  for (genvar g = 0; g < D; g++) begin : g_dk
    int v = 0;
    always @(posedge bus.DigitStep[g] or negedge Rst)
      if (!Rst) v <= 0;
      else if (bus.DigitSet) v <= oh2i(bus.DigitIn[g]);
      else v <= bus.DigitReverse ? (v + 9) % 10 : (v + 1) % 10;
    assign bus.DigitOut[g] = 10'(1) << v;
  end

  function automatic int chain_val();
    int r = 0;
    for (int d = D - 1; d >= 0; d--) r = r * 10 + oh2i(bus.DigitOut[d]);
    return r;
  endfunction

  function automatic logic [D-1:0][9:0] mk(input int v);
    logic [D-1:0][9:0] r;
    logic [9:0] one;
    one = 10'd1;
    for (int d = 0; d < D; d++) begin
      r[d] = one << (v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Pulse monitor, sampled mid-cycle
  int pc[$];
  logic [D-1:0] pm[$];
  logic pr[$];
  logic ps[$];
  int viol = 0;
  logic p_set = 1'b0, p_rev = 1'b0;
  logic [D-1:0][9:0] p_in = '0;
  always @(negedge Clk) begin
    if (|bus.DigitStep) begin
      pc.push_back(cyc);
      pm.push_back(bus.DigitStep);
      pr.push_back(bus.DigitReverse);
      ps.push_back(bus.DigitSet);
      if (p_set !== bus.DigitSet || p_rev !== bus.DigitReverse || p_in !== bus.DigitIn) viol++;
    end
    p_set = bus.DigitSet;
    p_rev = bus.DigitReverse;
    p_in  = bus.DigitIn;
  end

  // Issue one request; lat = edges from acceptance to Done (60 = timeout)
  task automatic do_op(input logic dec, input logic load, input logic [D-1:0][9:0] sv,
                       input bit hold, output int lat);
    int w = 0;
    while (bus.Ready !== 1'b1 && w < 20) begin @(posedge Clk); #1; w++; end
    @(negedge Clk);
    pc.delete(); pm.delete(); pr.delete(); ps.delete(); viol = 0;
    bus.Request = 1'b1; bus.Dec = dec; bus.Load = load; bus.SetValue = sv;
    @(posedge Clk); #1;
    if (!hold) bus.Request = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge Clk); lat++; #1;
      if (bus.Done === 1'b1) break;
    end
    bus.Request = 1'b0;
  endtask

  // Reference for a count op: new value, digits stepped, wrap-around
  function automatic void exp_count(input int v, input bit dec, output int nv, output int n, output bit ovf);
    int t;
    nv  = dec ? (v + M - 1) % M : (v + 1) % M;
    ovf = dec ? (v == 0) : (v == M - 1);
    n = 1; t = v;
    while (n < D && (t % 10) == (dec ? 0 : 9)) begin t = t / 10; n++; end
  endfunction

  task automatic test_reset();
    bus.Request = 0; bus.Dec = 0; bus.Load = 0; bus.SetValue = '0;
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    nchk++; if (bus.Ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got=%b exp=1", bus.Ready); end
    nchk++; if (bus.Zero !== 1'b1) begin nfail++; $display("FAIL reset_zero got=%b exp=1", bus.Zero); end
    nchk++; if (bus.DigitStep !== '0 || bus.DigitSet !== 1'b0 || bus.DigitReverse !== 1'b0 || bus.DigitIn !== '0)
      begin nfail++; $display("FAIL reset_drive step=%b set=%b rev=%b in=%h exp=0", bus.DigitStep, bus.DigitSet, bus.DigitReverse, bus.DigitIn); end
    nchk++; if (bus.Done !== 1'b0 || bus.Overflow !== 1'b0 || bus.Error !== 1'b0)
      begin nfail++; $display("FAIL reset_flags done=%b ovf=%b err=%b exp=0", bus.Done, bus.Overflow, bus.Error); end
    nchk++; if (chain_val() != 0) begin nfail++; $display("FAIL reset_value got=%0d exp=0", chain_val()); end
  endtask

  task automatic test_inc_basic();
    int lat;
    do_op(1'b0, 1'b0, '0, 1'b0, lat);
    nchk++; if (lat != 5) begin nfail++; $display("FAIL inc_latency got=%0d exp=5", lat); end
    nchk++; if (chain_val() != 1) begin nfail++; $display("FAIL inc_value got=%0d exp=1", chain_val()); end
    nchk++; if (pm.size() != 1 || pm[0] !== 3'b001 || pr[0] !== 1'b0)
      begin nfail++; $display("FAIL inc_pulse count=%0d exp=1 mask/rev wrong", pm.size()); end
    nchk++; if (bus.Zero !== 1'b0 || bus.Overflow !== 1'b0)
      begin nfail++; $display("FAIL inc_flags zero=%b ovf=%b exp=0,0", bus.Zero, bus.Overflow); end
  endtask

  task automatic test_ripple();
    int lat;
    logic [D-1:0] one;
    do_op(1'b0, 1'b1, mk(99), 1'b0, lat);
    do_op(1'b0, 1'b0, '0, 1'b0, lat);
    nchk++; if (lat != 11) begin nfail++; $display("FAIL ripple_latency got=%0d exp=11", lat); end
    nchk++; if (chain_val() != 100) begin nfail++; $display("FAIL ripple_value got=%0d exp=100", chain_val()); end
    nchk++; if (pm.size() != 3) begin nfail++; $display("FAIL ripple_pulses got=%0d exp=3", pm.size()); end
    else begin
      one = 1;
      for (int i = 0; i < 3; i++) begin
        nchk++; if (pm[i] !== (one << i)) begin nfail++; $display("FAIL ripple_order%0d got=%b exp=%b", i, pm[i], one << i); end
        if (i > 0) begin
          nchk++; if (pc[i] - pc[i-1] != 3) begin nfail++; $display("FAIL ripple_gap%0d got=%0d exp=3", i, pc[i] - pc[i-1]); end
        end
      end
    end
    nchk++; if (bus.Overflow !== 1'b0) begin nfail++; $display("FAIL ripple_ovf got=%b exp=0", bus.Overflow); end
  endtask

  task automatic test_wrap();
    int lat;
    do_op(1'b0, 1'b1, mk(999), 1'b0, lat);
    do_op(1'b0, 1'b0, '0, 1'b0, lat);
    nchk++; if (chain_val() != 0 || pm.size() != 3) begin nfail++; $display("FAIL wrap_up value=%0d pulses=%0d exp=0,3", chain_val(), pm.size()); end
    nchk++; if (bus.Overflow !== 1'b1 || bus.Zero !== 1'b1) begin nfail++; $display("FAIL wrap_up_flags ovf=%b zero=%b exp=1,1", bus.Overflow, bus.Zero); end
    do_op(1'b1, 1'b0, '0, 1'b0, lat);
    nchk++; if (chain_val() != 999 || pm.size() != 3 || lat != 11)
      begin nfail++; $display("FAIL wrap_down value=%0d pulses=%0d lat=%0d exp=999,3,11", chain_val(), pm.size(), lat); end
    nchk++; if (pm.size() == 3 && (pr[0] !== 1'b1 || pr[2] !== 1'b1)) begin nfail++; $display("FAIL wrap_down_rev got=%b%b exp=11", pr[0], pr[2]); end
    nchk++; if (bus.Overflow !== 1'b1 || bus.Zero !== 1'b0) begin nfail++; $display("FAIL wrap_down_flags ovf=%b zero=%b exp=1,0", bus.Overflow, bus.Zero); end
  endtask

  task automatic test_load();
    int lat;
    logic [D-1:0][9:0] bad;
    do_op(1'b0, 1'b1, mk(507), 1'b0, lat);
    nchk++; if (lat != 4) begin nfail++; $display("FAIL load_latency got=%0d exp=4", lat); end
    nchk++; if (chain_val() != 507) begin nfail++; $display("FAIL load_value got=%0d exp=507", chain_val()); end
    nchk++; if (pm.size() != 1 || pm[0] !== 3'b111 || ps[0] !== 1'b1)
      begin nfail++; $display("FAIL load_pulse count=%0d exp=1 all-digit with Set", pm.size()); end
    nchk++; if (viol != 0) begin nfail++; $display("FAIL load_setup_stable got=%0d exp=0", viol); end
    nchk++; if (bus.Error !== 1'b0) begin nfail++; $display("FAIL load_err got=%b exp=0", bus.Error); end
    bad = mk(507);
    bad[1] = 10'b0000000011;
    do_op(1'b0, 1'b1, bad, 1'b0, lat);
    nchk++; if (lat != 2) begin nfail++; $display("FAIL badload_latency got=%0d exp=2", lat); end
    nchk++; if (bus.Error !== 1'b1 || pm.size() != 0)
      begin nfail++; $display("FAIL badload err=%b pulses=%0d exp=1,0", bus.Error, pm.size()); end
    nchk++; if (chain_val() != 507) begin nfail++; $display("FAIL badload_value got=%0d exp=507", chain_val()); end
  endtask

  task automatic test_random();
    int lat, v, nv, n;
    bit ovf, dec;
    for (int it = 0; it < 24; it++) begin
      case (it % 4)
        0: v = $urandom_range(0, M - 1);
        1: v = $urandom_range(0, 9) * 100 + 99;
        2: v = $urandom_range(0, 9) * 100;
        default: v = $urandom_range(0, 1) ? 0 : M - 1;
      endcase
      dec = 1'($urandom_range(0, 1));
      do_op(1'b0, 1'b1, mk(v), 1'b0, lat);
      exp_count(v, dec, nv, n, ovf);
      do_op(dec, 1'b0, '0, 1'b0, lat);
      nchk++;
      if (chain_val() != nv || pm.size() != n || lat != 3 * n + 2 || bus.Overflow !== ovf || bus.Zero !== (nv == 0) || viol != 0) begin
        nfail++;
        $display("FAIL rand%0d v=%0d dec=%0d got val=%0d pulses=%0d lat=%0d ovf=%b zero=%b viol=%0d exp val=%0d pulses=%0d lat=%0d ovf=%b zero=%b",
                 it, v, dec, chain_val(), pm.size(), lat, bus.Overflow, bus.Zero, viol, nv, n, 3 * n + 2, ovf, nv == 0);
      end
    end
  endtask

  task automatic test_held_request();
    int lat;
    do_op(1'b0, 1'b1, mk(0), 1'b0, lat);
    do_op(1'b0, 1'b0, '0, 1'b1, lat);
    nchk++; if (lat != 5 || chain_val() != 1 || pm.size() != 1)
      begin nfail++; $display("FAIL held_req lat=%0d value=%0d pulses=%0d exp=5,1,1", lat, chain_val(), pm.size()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_op(1'b0, 1'b1, mk(99), 1'b0, lat);
    @(negedge Clk);
    bus.Request = 1'b1; bus.Dec = 1'b0; bus.Load = 1'b0;
    @(posedge Clk);
    repeat (5) @(posedge Clk);
    #1;
    nchk++; if (bus.Ready !== 1'b0) begin nfail++; $display("FAIL busy_ready got=%b exp=0", bus.Ready); end
    #1 Rst = 1'b0;
    #1;
    nchk++; if (bus.Ready !== 1'b1 || bus.Zero !== 1'b1 || bus.DigitStep !== '0 || bus.Done !== 1'b0)
      begin nfail++; $display("FAIL rst_mid ready=%b zero=%b step=%b done=%b exp=1,1,0,0", bus.Ready, bus.Zero, bus.DigitStep, bus.Done); end
    nchk++; if (bus.DigitSet !== 1'b0 || bus.DigitReverse !== 1'b0 || bus.DigitIn !== '0 || bus.Overflow !== 1'b0 || bus.Error !== 1'b0)
      begin nfail++; $display("FAIL rst_mid_drive set=%b rev=%b ovf=%b err=%b exp=0", bus.DigitSet, bus.DigitReverse, bus.Overflow, bus.Error); end
    nchk++; if (chain_val() != 0) begin nfail++; $display("FAIL rst_mid_value got=%0d exp=0", chain_val()); end
    bus.Request = 1'b0;
    @(negedge Clk); Rst = 1'b1;
    do_op(1'b0, 1'b0, '0, 1'b0, lat);
    nchk++; if (lat != 5 || chain_val() != 1) begin nfail++; $display("FAIL post_rst_inc lat=%0d value=%0d exp=5,1", lat, chain_val()); end
  endtask

  initial begin
    test_reset();
    test_inc_basic();
    test_ripple();
    test_wrap();
    test_load();
    test_random();
    test_held_request();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dekatron_chain_ctrl.md
Name: dekatron_chain_ctrl

Overview:
Sequencer that drives a chain of DIGITS dekatron ring counters, digit 0 least significant. It issues per-digit Step pulses, Reverse and Set/In so the chain behaves as a DIGITS-decade decimal up/down counter. Carry and borrow ripple one digit at a time, as on the tube hardware. It reads each dekatron's one-hot Out back to decide carry, zero and validity. It sits directly upstream of the dekatron instances and shares their Rst.

Parameters:
DIGITS, 3, number of chained dekatrons (1..8).
WIDTH, 10, one-hot positions per dekatron (fixed at 10).

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-low reset; same net as the dekatrons' Rst.
Request  input  1  operation request; accepted only when Ready=1.
Dec  input  1  1 = decrement by one, 0 = increment by one.
Load  input  1  1 = load SetValue into all digits; takes priority over Dec.
SetValue  input  DIGITS*WIDTH  one-hot value per digit for Load.
DigitOut  input  DIGITS*WIDTH  Out buses of the dekatrons, read back.
DigitStep  output  DIGITS  per-digit Step pulses.
DigitReverse  output  1  Reverse line shared by all digits (1 = count down).
DigitSet  output  1  Set line shared by all digits.
DigitIn  output  DIGITS*WIDTH  In buses of the dekatrons.
Ready  output  1  idle, can accept Request.
Done  output  1  one-cycle completion pulse.
Overflow  output  1  last op carried/borrowed out of the top digit.
Error  output  1  last op saw a non-one-hot digit.
Zero  output  1  all digits at position 0 after the last op.

Behaviour:
- Reset (Rst=0, async): FSM to IDLE; DigitStep=0, DigitReverse=0, DigitSet=0, DigitIn=0, Ready=1, Done=0, Overflow=0, Error=0, Zero=1.
- All outputs are registered; DigitStep is glitch-free, since dekatrons clock on its rising edge.
- States: IDLE, SETUP, EVAL, PULSE, HOLD, DONE.
- IDLE: Ready=1. On Request=1, latch Dec and Load, clear Overflow and Error, go to SETUP, set Ready=0 on the next cycle.
- Request while Ready=0 is ignored, not queued.
- SETUP:
  - Count op: DigitReverse=Dec, DigitSet=0, digit index k=0, go to EVAL.
  - Load op: if any SetValue digit is not exactly one-hot, set Error=1 and go to DONE with no pulses. Otherwise drive DigitIn=SetValue and DigitSet=1, then go to PULSE with all DigitStep bits selected.
  - Reverse, Set and In are stable one full cycle before any Step rise.
- EVAL (count only): sample DigitOut digit k before stepping.
  - Not one-hot: Error=1, go to DONE; no further pulses.
  - carry = (!Dec and digit==9) or (Dec and digit==0).
  - Go to PULSE.
- PULSE: the selected DigitStep bit(s) = 1 for exactly one cycle.
- HOLD: all DigitStep=0.
  - Load op: go to DONE.
  - Count op, carry=0: go to DONE.
  - Count op, carry=1 and k<DIGITS-1: k=k+1, go to EVAL.
  - Count op, carry=1 and k=DIGITS-1: Overflow=1, go to DONE. The chain has wrapped (999->000 or 000->999 for DIGITS=3).
- DONE: Done=1 for one cycle.
  - Zero = all DigitOut digits equal position 0 (bit 0 set).
  - DigitSet=0, DigitIn=0, DigitReverse=0.
  - Next cycle: IDLE, Ready=1.
- Latency, with the accepting edge as edge 0:
  - Count stepping n digits: Done high 3n+2 cycles later.
  - Load: Done at +4.
  - Rejected Load: Done at +2.
- Overflow, Error and Zero hold their value until the next accepted Request (Zero until the next DONE).
- Rst mid-operation: immediate abort. Dekatrons reset to position 0 simultaneously, so Zero=1 stays consistent.

Decomposition:
- Shared package dekatron_pkg:
  - WIDTH=10.
  - Constants POS0=10'b0000000001, POS9=10'b1000000000.
  - FSM state enum.
- Sub-module dekatron_onehot_decode (combinational): one WIDTH bus in; is_valid, is_zero, is_nine out. Instanced per digit for EVAL, Zero and the SetValue check.

Test Plan:
- Reset, no request -> Ready=1, Zero=1, all DigitStep=0; dekatron models at 000.
- Increment at 000 -> one pulse on DigitStep[0] with Reverse=0; Done at +5; value 001; Zero=0, Overflow=0.
- Increment at 099 -> pulses on digits 0, 1, 2 in that order, each one cycle wide and 3 cycles apart; Done at +11; value 100; Overflow=0.
- Increment at 999 -> three pulses; value 000; Overflow=1, Zero=1. Then decrement -> Reverse=1, three pulses; value 999; Overflow=1.
- Load SetValue=5,0,7 -> DigitSet=1 with DigitIn stable before a single simultaneous pulse on all Steps; Done at +4; DigitOut=507. Load with digit 1 = 10'b0000000011 -> Error=1, no Step pulses, Done at +2.
- Request held high while busy and Rst pulsed low mid-ripple on 099->100 -> extra requests ignored; on Rst all outputs return to reset values at once; next increment yields 001.
